// File: rtl/timestamp_readout.sv
// Buffers captured 48-bit timestamps and returns them to the host as three
// 16-bit words, most-significant word first, with sticky drop detection.
module timestamp_readout #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [47:0]   timestamp,
  input  logic          capture,
  input  logic          rd_en,
  input  logic          clr_ovf,
  output logic [15:0]   data_out,
  output logic          data_valid,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW = 48;
  localparam int unsigned WW = 16;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t          state;
  logic [TW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [TW-1:0]   out_reg;
  logic [1:0]      word_idx;

  logic            fifo_nonempty_c;
  logic            last_word_read_c;
  logic            pop_c;
  logic            accept_c;
  logic            drop_c;
  logic [TW-1:0]   head_c;

  // Pop whenever the output register is free or its last word is consumed now.
  always_comb begin
    fifo_nonempty_c  = (count != '0);
    last_word_read_c = (state == SEND) && rd_en && (word_idx == 2'd2);
    pop_c            = fifo_nonempty_c && ((state == IDLE) || last_word_read_c);
    accept_c         = capture && ((count < CW'(DEPTH)) || pop_c);
    drop_c           = capture && !accept_c;
    head_c           = mem[rd_ptr];
  end

  // Storage carries no reset; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem[wr_ptr] <= timestamp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      out_reg    <= '0;
      word_idx   <= 2'd0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      if (accept_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(accept_c) - CW'(pop_c);

      // A drop on the same edge as a clear must leave the flag set.
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pop_c) begin
            state      <= SEND;
            out_reg    <= head_c;
            word_idx   <= 2'd0;
            data_out   <= head_c[TW-1 -: WW];
            data_valid <= 1'b1;
          end
        end
        SEND: begin
          if (rd_en) begin
            if (word_idx != 2'd2) begin
              word_idx <= word_idx + 2'd1;
              data_out <= (word_idx == 2'd0) ? out_reg[31:16] : out_reg[15:0];
            end else if (pop_c) begin
              out_reg    <= head_c;
              word_idx   <= 2'd0;
              data_out   <= head_c[TW-1 -: WW];
            end else begin
              state      <= IDLE;
              word_idx   <= 2'd0;
              data_out   <= '0;
              data_valid <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          data_valid <= 1'b0;
          data_out   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timestamp_readout.sv
// Directed plus random checks of timestamp_readout against a queue-based
// model of the capture buffer and the three-word readout.
module tb_timestamp_readout;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [47:0]   timestamp;
  logic          capture;
  logic          rd_en;
  logic          clr_ovf;
  logic [15:0]   data_out;
  logic          data_valid;
  logic [CW-1:0] count;
  logic          overflow;

  timestamp_readout #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .timestamp  (timestamp),
    .capture    (capture),
    .rd_en      (rd_en),
    .clr_ovf    (clr_ovf),
    .data_out   (data_out),
    .data_valid (data_valid),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: pending timestamps, the one being read out, and the flag.
  logic [47:0] m_q[$];
  bit          m_valid;
  logic [47:0] m_out;
  int          m_idx;
  bit          m_ovf;

  function automatic logic [15:0] exp_word();
    if (!m_valid) return 16'h0000;
    return m_out[47 - 16*m_idx -: 16];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_valid = 1'b0;
    m_out   = '0;
    m_idx   = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge(input bit cap, input logic [47:0] ts, input bit rd, input bit clr);
    bit finishing;
    bit pop;
    bit accept;
    finishing = m_valid && rd && (m_idx == 2);
    pop       = (m_q.size() > 0) && (!m_valid || finishing);
    accept    = cap && ((m_q.size() < DEPTH) || pop);
    if (m_valid && rd && m_idx < 2) m_idx++;
    if (pop) begin
      m_out   = m_q.pop_front();
      m_idx   = 0;
      m_valid = 1'b1;
    end else if (finishing) begin
      m_valid = 1'b0;
      m_idx   = 0;
    end
    if (accept) m_q.push_back(ts);
    if (cap && !accept) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_out"},   48'(data_out),   48'(exp_word()));
    chk({tag, ".data_valid"}, 48'(data_valid), 48'(m_valid));
    chk({tag, ".count"},      48'(count),      48'(m_q.size()));
    chk({tag, ".overflow"},   48'(overflow),   48'(m_ovf));
  endtask

  // One clock: drive inputs, model the edge, check outputs just after it.
  task automatic step(input string tag, input bit cap, input logic [47:0] ts,
                      input bit rd, input bit clr);
    capture   = cap;
    timestamp = ts;
    rd_en     = rd;
    clr_ovf   = clr;
    @(posedge clk);
    model_edge(cap, ts, rd, clr);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    capture = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0; timestamp = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    capture = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0; timestamp = '0;
    #2;
    do_reset();

    // Single capture and three-word readout.
    step("single_cap", 1'b1, 48'h1234_5678_9ABC, 1'b0, 1'b0);
    chk("single_cap.valid_still_low", 48'(data_valid), 48'd0);
    chk("single_cap.count_one", 48'(count), 48'd1);
    step("single_load", 1'b0, '0, 1'b0, 1'b0);
    chk("single_load.word0", 48'(data_out), 48'h1234);
    step("single_rd0", 1'b0, '0, 1'b1, 1'b0);
    chk("single_rd0.word1", 48'(data_out), 48'h5678);
    step("single_rd1", 1'b0, '0, 1'b1, 1'b0);
    chk("single_rd1.word2", 48'(data_out), 48'h9ABC);
    step("single_rd2", 1'b0, '0, 1'b1, 1'b0);
    chk("single_rd2.valid_low", 48'(data_valid), 48'd0);

    // Five captures fill FIFO plus output register; sixth is dropped.
    for (int i = 1; i <= 5; i++) step("burst", 1'b1, 48'(i), 1'b0, 1'b0);
    chk("burst.no_ovf", 48'(overflow), 48'd0);
    chk("burst.full", 48'(count), 48'd4);
    step("burst_drop", 1'b1, 48'd6, 1'b0, 1'b0);
    chk("burst_drop.ovf", 48'(overflow), 48'd1);
    for (int i = 0; i < 15; i++) begin
      step("drain", 1'b0, '0, 1'b1, 1'b0);
      if (i < 14) chk("drain.no_gap", 48'(data_valid), 48'd1);
    end
    chk("drain.empty_valid", 48'(data_valid), 48'd0);
    step("ovf_clear", 1'b0, '0, 1'b0, 1'b1);

    // Full FIFO, capture on the same edge as the word-2 read.
    for (int i = 1; i <= 5; i++) step("refill", 1'b1, 48'(16 * i), 1'b0, 1'b0);
    step("refill_rd0", 1'b0, '0, 1'b1, 1'b0);
    step("refill_rd1", 1'b0, '0, 1'b1, 1'b0);
    step("full_cap_pop", 1'b1, 48'hAAAA_BBBB_CCCC, 1'b1, 1'b0);
    chk("full_cap_pop.count4", 48'(count), 48'd4);
    chk("full_cap_pop.ovf0", 48'(overflow), 48'd0);

    // Clear and drop on the same edge: set wins.
    step("clr_and_drop", 1'b1, 48'h1, 1'b0, 1'b1);
    chk("clr_and_drop.ovf1", 48'(overflow), 48'd1);
    step("clr_alone", 1'b0, '0, 1'b0, 1'b1);
    chk("clr_alone.ovf0", 48'(overflow), 48'd0);

    // Asynchronous reset mid-readout after word 1, count=2.
    do_reset();
    step("pre_rst_c1", 1'b1, 48'h0101_0202_0303, 1'b0, 1'b0);
    step("pre_rst_c2", 1'b1, 48'h0404_0505_0606, 1'b0, 1'b0);
    step("pre_rst_c3", 1'b1, 48'h0707_0808_0909, 1'b0, 1'b0);
    step("pre_rst_rd", 1'b0, '0, 1'b1, 1'b0);
    chk("pre_rst.count2", 48'(count), 48'd2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_rst.data_out0", 48'(data_out), 48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("post_rst_idle", 1'b0, '0, 1'b1, 1'b0);

    // rd_en pulses in IDLE move nothing; next capture reads back intact.
    for (int i = 0; i < 3; i++) step("idle_rd", 1'b0, '0, 1'b1, 1'b0);
    step("idle_cap", 1'b1, 48'hFEDC_BA98_7654, 1'b1, 1'b0);
    step("idle_load", 1'b0, '0, 1'b0, 1'b0);
    chk("idle_load.word0", 48'(data_out), 48'hFEDC);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 99) < 45),
           {16'($urandom), 32'($urandom)},
           ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 8));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/timestamp_readout.md
# timestamp_readout

Captures 48-bit timestamps from the free-running time base and returns them to the host as 16-bit words, most-significant word first. It is the read-back path to the host's 3×16-bit count-write path. It buffers up to DEPTH captured timestamps, so bursts of capture events are not lost while the host drains words. It flags any capture dropped because the buffer was full.

## Interface
- DEPTH, 4: buffer entries (power of two, ≥2).
- CW, 3: width of `count`, equal to log2(DEPTH)+1.

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- timestamp  in  48  current time-base value
- capture  in  1  single-cycle request to store `timestamp`
- rd_en  in  1  host consumes current `data_out` word
- clr_ovf  in  1  clears `overflow`
- data_out  out  16  current word of the timestamp being read out
- data_valid  out  1  `data_out` holds an unread word
- count  out  CW  timestamps waiting in the buffer; excludes the one being read out
- overflow  out  1  sticky: at least one capture was dropped

## Operation
- Buffer: DEPTH×48 circular FIFO with write pointer, read pointer and occupancy `count`.
  - Pointers wrap modulo DEPTH.
- Capture: `capture`=1 at an edge writes `timestamp` sampled at that same edge.
  - Accepted if `count`<DEPTH, or if a pop happens on the same edge.
  - Otherwise the capture is dropped and `overflow` is set.
- Readout FSM has two states.
  - IDLE: `data_valid`=0. If `count`>0 at an edge, pop the head entry into a 48-bit output register, set word_idx=0 and go to SEND.
  - SEND: `data_valid`=1. `data_out` = out_reg[47:32], [31:16] or [15:0] for word_idx 0, 1 or 2.
    - `rd_en`=1 with word_idx<2: word_idx increments.
    - `rd_en`=1 with word_idx=2 and `count`>0: pop the next entry, word_idx=0, stay in SEND with no bubble.
    - `rd_en`=1 with word_idx=2 and `count`=0: go to IDLE.
- `rd_en` is ignored in IDLE.
- `count` next value = count + accepted_write − pop.
  - Simultaneous write and pop leaves `count` unchanged.
  - A capture into an empty FIFO on the same edge as a pop attempt is not popped that edge; pop requires `count`>0 before the edge.
- `overflow`: set on a dropped capture; cleared by `clr_ovf`. If both happen on the same edge, set wins.
- Word order matches the host write path: the first word returned is bits [47:32].

## Timing
- Reset (rst_n=0, asynchronous): FSM enters IDLE, pointers are 0, `count`=0, `data_out`=16'h0000, `data_valid`=0, `overflow`=0.
  - Buffer contents are don't-care.
  - Reset mid-readout discards all stored and partially read timestamps.
- Capture-to-valid latency, with the FIFO empty and FSM in IDLE:
  - `capture` at edge k → `count`=1 after edge k.
  - `data_valid`=1 and `count`=0 after edge k+1.
- Each word is held until the `rd_en` edge that consumes it. Throughput is one word per cycle with `rd_en` held high.
- Back-to-back entries: the edge consuming word 2 loads the next entry's word 0, so `data_valid` stays 1.
- Total storage is DEPTH entries plus 1 in the output register.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Reset then single capture of 48'h1234_5678_9ABC at edge k.
  - Required: `data_valid` rises after edge k+1.
  - Reads return 16'h1234, 16'h5678, 16'h9ABC.
  - `data_valid`=0 after the third `rd_en`.
- Five captures on consecutive cycles (values 1–5) with no reads, DEPTH=4.
  - Required: values 1–5 are held (4 in FIFO + 1 in the output register) and `overflow` stays 0.
  - A sixth capture is dropped and `overflow`=1.
  - Draining with `rd_en` held high yields 15 words with no `data_valid` gap, in order 1–5.
- FIFO full (`count`=4) with `capture` and a word-2 `rd_en` on the same edge.
  - Required: capture accepted, `count` stays 4, `overflow` unchanged.
- `clr_ovf` and a dropped capture on the same edge.
  - Required: `overflow`=1.
  - A later `clr_ovf` alone gives `overflow`=0.
- Assert rst_n low asynchronously mid-readout, after word 1 of the entry and with `count`=2.
  - Required: outputs go immediately to reset values.
  - After release, reads see `data_valid`=0 until a new capture.
- `rd_en` pulses while IDLE.
  - Required: no state change, `data_out`=0, no pointer movement.
